// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter: grants one producer per burst onto a shared sync_fifo.
// Optional per-requester accepted-beat counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 9,
    parameter int MAX_BURST = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_din,
    input  logic                     fifo_full,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                     stat_clr,
    output logic [N_REQ*16-1:0]      stat_beats
`endif
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state, state_nx;
    logic [N_REQ-1:0]   grant_nx;
    logic [IDX_W-1:0]   gnt_idx, gnt_idx_nx;
    logic [IDX_W-1:0]   last_gnt, last_gnt_nx;
    logic [CNT_W-1:0]   beat_cnt, beat_cnt_nx;
    logic [IDX_W-1:0]   sel_idx, cand;
    logic               sel_found;
    logic               accept;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last_gnt) + k) % N_REQ);
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            gnt_idx  <= '0;
            last_gnt <= IDX_W'(N_REQ - 1);
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            gnt_idx  <= gnt_idx_nx;
            last_gnt <= last_gnt_nx;
            beat_cnt <= beat_cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        grant_nx    = grant;
        gnt_idx_nx  = gnt_idx;
        last_gnt_nx = last_gnt;
        beat_cnt_nx = beat_cnt;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nx   = BURST;
                    gnt_idx_nx = sel_idx;
                    grant_nx   = N_REQ'(1) << sel_idx;
                end
            end
            BURST: begin
                accept = req_valid[gnt_idx] & ~fifo_full;
                // A full FIFO with valid held neither accepts nor releases.
                if (!req_valid[gnt_idx] ||
                    (accept && (req_last[gnt_idx] || beat_cnt == CNT_W'(MAX_BURST - 1)))) begin
                    state_nx    = IDLE;
                    grant_nx    = '0;
                    last_gnt_nx = gnt_idx;
                    beat_cnt_nx = '0;
                end else if (accept) begin
                    beat_cnt_nx = beat_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy       = (state == BURST);
    assign fifo_wr_en = accept;
    assign req_ready  = accept ? grant : '0;

    always_comb begin
        fifo_din = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (busy && gnt_idx == IDX_W'(i))
                fifo_din = req_data[i*WIDTH +: WIDTH];
        end
    end

`ifdef FIFO_ARB_STATS_EN
    for (genvar i = 0; i < N_REQ; i++) begin : g_stat
        logic [15:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt <= '0;
            else if (stat_clr)
                cnt <= '0;
            else if (req_ready[i] && cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;
        end
        assign stat_beats[i*16 +: 16] = cnt;
    end
`endif

endmodule
